// File: rtl/regfile_sb_if.sv
// Register file / scoreboard bus between decode, writeback and regfile_sb.
// Groups read, write, link, issue and hazard signals behind two modports.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 16,
  parameter int NRD  = 3
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD-1:0]      re;
  logic [NRD*XLEN-1:0] rd;
  logic [XLEN-1:0]     r15;
  logic                we_a;
  logic [AW-1:0]       wa_a;
  logic [XLEN-1:0]     wd_a;
  logic                we_b;
  logic [AW-1:0]       wa_b;
  logic [XLEN-1:0]     wd_b;
  logic                bl;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [NREG-1:0]     busy;
  logic                stall;
  logic                err;

  modport master (
    output ra, re, r15,
    output we_a, wa_a, wd_a,
    output we_b, wa_b, wd_b,
    output bl, issue_valid, issue_rd,
    input  rd, busy, stall, err
  );

  modport slave (
    input  ra, re, r15,
    input  we_a, wa_a, wd_a,
    input  we_b, wa_b, wd_b,
    input  bl, issue_valid, issue_rd,
    output rd, busy, stall, err
  );
endinterface

// File: rtl/regfile_sb.sv
// NREG x XLEN register file with link write, PC alias, optional bypass
// and a load scoreboard driving a combinational stall.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 3,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic     clk,
  input  logic     reset_n,
  regfile_sb_if.slave bus
);

  localparam logic [AW-1:0] LR = AW'(NREG - 2);
  localparam logic [AW-1:0] PC = AW'(NREG - 1);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_v;
  logic [NREG-1:0] clr_v;
  logic            err_q;
  logic            err_d;
  logic [XLEN-1:0] link;
  logic            commit_a;
  logic            commit_b;
  logic [NRD-1:0]  hit;

  assign link = bus.r15 - XLEN'(4);

  // bl owns LR; port A owns a register shared with port B
  assign commit_a = bus.we_a && (bus.wa_a != PC)
                 && !(bus.bl && bus.wa_a == LR);
  assign commit_b = bus.we_b && (bus.wa_b != PC)
                 && !(bus.bl && bus.wa_b == LR)
                 && !(commit_a && bus.wa_a == bus.wa_b);

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (bus.issue_valid && bus.issue_rd != PC)
      set_v[bus.issue_rd] = 1'b1;
    if (bus.we_b)
      clr_v[bus.wa_b] = 1'b1;
    busy_d = (busy_q & ~clr_v) | set_v;
  end

  always_comb begin
    err_d = err_q;
    if (bus.issue_valid && bus.issue_rd != PC
        && busy_q[bus.issue_rd] && !clr_v[bus.issue_rd])
      err_d = 1'b1;
    if (bus.we_b && !busy_q[bus.wa_b]
        && !(bus.bl && bus.wa_b == LR))
      err_d = 1'b1;
    if (bus.we_a && busy_q[bus.wa_a])
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (commit_b)
        rf[bus.wa_b] <= bus.wd_b;
      if (commit_a)
        rf[bus.wa_a] <= bus.wd_a;
      if (bus.bl)
        rf[LR] <= link;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;

    assign a = bus.ra[g*AW +: AW];

    always_comb begin
      d = rf[a];
      if (a == PC)
        d = bus.r15;
      else if (BYPASS != 0) begin
        if (bus.bl && a == LR)
          d = link;
        else if (commit_a && bus.wa_a == a)
          d = bus.wd_a;
        else if (commit_b && bus.wa_b == a)
          d = bus.wd_b;
      end
    end

    assign bus.rd[g*XLEN +: XLEN] = d;
    assign hit[g] = bus.re[g] & busy_q[a] & (a != PC);
  end

  assign bus.stall = |hit;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, link, scoreboard, err
// and asynchronous reset behaviour with hand-computed expectations.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int NRD  = 3;
  localparam int AW   = 4;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.ra = '0;
    bus.re = '0;
    bus.we_a = 1'b0;
    bus.wa_a = '0;
    bus.wd_a = '0;
    bus.we_b = 1'b0;
    bus.wa_b = '0;
    bus.wd_b = '0;
    bus.bl = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input int idx);
    bus.ra[p*AW +: AW] = AW'(idx);
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] got;
    logic [XLEN-1:0] exp;
    reset_n = 1'b0;
    idle();
    bus.r15 = 32'h0000_1008;
    #2;
    for (int idx = 0; idx < NREG; idx++) begin
      for (int p = 0; p < NRD; p++) set_ra(p, idx);
      #1;
      for (int p = 0; p < NRD; p++) begin
        got = bus.rd[p*XLEN +: XLEN];
        exp = (idx == NREG - 1) ? 32'h0000_1008 : 32'h0;
        total++;
        if (got !== exp)
          $display("FAIL reset_rd idx=%0d port=%0d got=%h exp=%h",
                   idx, p, got, exp);
        else passed++;
      end
    end
    total++;
    if (bus.busy !== 16'h0)
      $display("FAIL reset_busy got=%h exp=0", bus.busy);
    else passed++;
    total++;
    if (bus.stall !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL reset_stall_err got=%b%b exp=00",
               bus.stall, bus.err);
    else passed++;
    idle();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    idle();
    bus.we_a = 1'b1;
    bus.wa_a = 4'd3;
    bus.wd_a = 32'hDEAD_BEEF;
    set_ra(0, 3);
    set_ra(1, 4);
    #1;
    total++;
    if (bus.rd[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL bypass_a got=%h exp=deadbeef", bus.rd[31:0]);
    else passed++;
    total++;
    if (bus.rd[63:32] !== 32'h0)
      $display("FAIL bypass_other got=%h exp=0", bus.rd[63:32]);
    else passed++;
    tick();
    idle();
    set_ra(2, 3);
    #1;
    total++;
    if (bus.rd[95:64] !== 32'hDEAD_BEEF || bus.err !== 1'b0)
      $display("FAIL write_a got=%h err=%b exp=deadbeef err=0",
               bus.rd[95:64], bus.err);
    else passed++;
  endtask

  task automatic test_link();
    idle();
    bus.r15 = 32'h0000_2010;
    bus.bl = 1'b1;
    bus.we_a = 1'b1;
    bus.wa_a = 4'd14;
    bus.wd_a = 32'h55;
    set_ra(0, 14);
    #1;
    total++;
    if (bus.rd[31:0] !== 32'h0000_200C)
      $display("FAIL link_bypass got=%h exp=200c", bus.rd[31:0]);
    else passed++;
    tick();
    idle();
    set_ra(0, 14);
    #1;
    total++;
    if (bus.rd[31:0] !== 32'h0000_200C)
      $display("FAIL link_commit got=%h exp=200c", bus.rd[31:0]);
    else passed++;
    bus.we_a = 1'b1;
    bus.wa_a = 4'd15;
    bus.wd_a = 32'h99;
    bus.r15 = 32'h0000_3000;
    set_ra(1, 15);
    #1;
    total++;
    if (bus.rd[63:32] !== 32'h0000_3000)
      $display("FAIL pc_nobypass got=%h exp=3000", bus.rd[63:32]);
    else passed++;
    tick();
    idle();
    set_ra(0, 15);
    set_ra(1, 14);
    set_ra(2, 3);
    #1;
    total++;
    if (bus.rd[31:0] !== 32'h0000_3000)
      $display("FAIL pc_alias got=%h exp=3000", bus.rd[31:0]);
    else passed++;
    total++;
    if (bus.rd[63:32] !== 32'h0000_200C
        || bus.rd[95:64] !== 32'hDEAD_BEEF)
      $display("FAIL pc_write_side got=%h,%h exp=200c,deadbeef",
               bus.rd[63:32], bus.rd[95:64]);
    else passed++;
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 4'd5;
    tick();
    idle();
    set_ra(0, 5);
    #1;
    total++;
    if (bus.stall !== 1'b0)
      $display("FAIL stall_no_re got=%b exp=0", bus.stall);
    else passed++;
    bus.re = 3'b001;
    #1;
    total++;
    if (bus.stall !== 1'b1 || bus.busy !== 16'h0020)
      $display("FAIL stall_busy got=%b busy=%h exp=1 busy=0020",
               bus.stall, bus.busy);
    else passed++;
    bus.we_b = 1'b1;
    bus.wa_b = 4'd5;
    bus.wd_b = 32'h77;
    #1;
    total++;
    if (bus.stall !== 1'b1 || bus.rd[31:0] !== 32'h77)
      $display("FAIL stall_wb_cycle got=%b rd=%h exp=1 rd=77",
               bus.stall, bus.rd[31:0]);
    else passed++;
    tick();
    idle();
    set_ra(0, 5);
    bus.re = 3'b001;
    #1;
    total++;
    if (bus.stall !== 1'b0 || bus.rd[31:0] !== 32'h77
        || bus.busy !== 16'h0 || bus.err !== 1'b0)
      $display("FAIL sb_clear got=%b rd=%h busy=%h err=%b exp=0 77 0 0",
               bus.stall, bus.rd[31:0], bus.busy, bus.err);
    else passed++;
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 4'd15;
    tick();
    idle();
    total++;
    if (bus.busy !== 16'h0 || bus.err !== 1'b0)
      $display("FAIL issue_pc got=%h err=%b exp=0 0", bus.busy, bus.err);
    else passed++;
  endtask

  task automatic test_err();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 4'd6;
    tick();
    bus.we_b = 1'b1;
    bus.wa_b = 4'd6;
    bus.wd_b = 32'hAB;
    tick();
    idle();
    set_ra(0, 6);
    #1;
    total++;
    if (bus.busy !== 16'h0040 || bus.err !== 1'b0
        || bus.rd[31:0] !== 32'hAB)
      $display("FAIL reissue got=%h err=%b rd=%h exp=0040 0 ab",
               bus.busy, bus.err, bus.rd[31:0]);
    else passed++;
    bus.we_b = 1'b1;
    bus.wa_b = 4'd6;
    bus.wd_b = 32'hCD;
    tick();
    idle();
    total++;
    if (bus.busy !== 16'h0 || bus.err !== 1'b0)
      $display("FAIL wb_clear got=%h err=%b exp=0 0", bus.busy, bus.err);
    else passed++;
    bus.we_b = 1'b1;
    bus.wa_b = 4'd7;
    bus.wd_b = 32'h11;
    tick();
    idle();
    set_ra(0, 7);
    #1;
    total++;
    if (bus.err !== 1'b1 || bus.rd[31:0] !== 32'h11)
      $display("FAIL err_wb_idle got=%b rd=%h exp=1 11",
               bus.err, bus.rd[31:0]);
    else passed++;
    bus.we_a = 1'b1;
    bus.wa_a = 4'd8;
    bus.wd_a = 32'h1;
    bus.we_b = 1'b1;
    bus.wa_b = 4'd8;
    bus.wd_b = 32'h2;
    set_ra(0, 8);
    #1;
    total++;
    if (bus.rd[31:0] !== 32'h1)
      $display("FAIL a_over_b_bypass got=%h exp=1", bus.rd[31:0]);
    else passed++;
    tick();
    idle();
    set_ra(0, 8);
    tick();
    total++;
    if (bus.rd[31:0] !== 32'h1 || bus.err !== 1'b1)
      $display("FAIL a_over_b got=%h err=%b exp=1 1",
               bus.rd[31:0], bus.err);
    else passed++;
  endtask

  task automatic test_async_reset();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 4'd2;
    tick();
    idle();
    total++;
    if (bus.busy !== 16'h0004)
      $display("FAIL busy2 got=%h exp=0004", bus.busy);
    else passed++;
    #1 reset_n = 1'b0;
    set_ra(0, 3);
    set_ra(1, 8);
    set_ra(2, 14);
    #1;
    total++;
    if (bus.busy !== 16'h0 || bus.err !== 1'b0)
      $display("FAIL async_sb got=%h err=%b exp=0 0", bus.busy, bus.err);
    else passed++;
    total++;
    if (bus.rd !== '0)
      $display("FAIL async_rf got=%h exp=0", bus.rd);
    else passed++;
    #1 reset_n = 1'b1;
    bus.we_b = 1'b1;
    bus.wa_b = 4'd2;
    bus.wd_b = 32'h5;
    tick();
    idle();
    set_ra(0, 2);
    #1;
    total++;
    if (bus.err !== 1'b1 || bus.rd[31:0] !== 32'h5
        || bus.busy !== 16'h0)
      $display("FAIL post_reset_wb err=%b rd=%h busy=%h exp=1 5 0",
               bus.err, bus.rd[31:0], bus.busy);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_bypass();
    test_link();
    test_scoreboard();
    test_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
